// File: rtl/timer_display.sv
// rtl/timer_display.sv - countdown seconds to BCD, multiplexed on a two-digit 7-segment display
// Optional build macro: TIMER_DISPLAY_BLINK_EN (blink the display while time_up is high)

module timer_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic       clk_o,
  input  logic       rst,
  input  logic [5:0] count,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       time_up
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state_q, state_d;
  logic        load, last_step;
  logic [5:0]  cnt_q, last_conv, conv_src, sr_q;
  logic [3:0]  tens_acc, ones_acc, tens_q, ones_q;
  logic [3:0]  tens_adj, ones_adj, tens_nx, ones_nx;
  logic [5:0]  sr_nx;
  logic [2:0]  step_q;
  logic        time_up_q;
  logic [RW-1:0] refresh_q;
  logic        sel_q;
  logic        blank;
  logic [3:0]  digit;

  // FSM state register
  always_ff @(posedge clk_o) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state: start on a new value, finish after the sixth shift
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    last_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (cnt_q != last_conv) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        if (step_q == 3'd5) begin
          last_step = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift the whole chain left
  always_comb begin
    tens_adj = (tens_acc >= 4'd5) ? tens_acc + 4'd3 : tens_acc;
    ones_adj = (ones_acc >= 4'd5) ? ones_acc + 4'd3 : ones_acc;
    tens_nx  = {tens_adj[2:0], ones_adj[3]};
    ones_nx  = {ones_adj[2:0], sr_q[5]};
    sr_nx    = {sr_q[4:0], 1'b0};
  end

  // Input sample, conversion datapath and displayed digits; partial results are dropped on reset
  always_ff @(posedge clk_o) begin
    if (!rst) begin
      cnt_q     <= '0;
      last_conv <= '0;
      conv_src  <= '0;
      sr_q      <= '0;
      tens_acc  <= '0;
      ones_acc  <= '0;
      step_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
      time_up_q <= 1'b1;
    end else begin
      cnt_q <= count;
      if (load) begin
        sr_q     <= cnt_q;
        conv_src <= cnt_q;
        tens_acc <= '0;
        ones_acc <= '0;
        step_q   <= '0;
      end else if (state_q == SHIFT) begin
        sr_q     <= sr_nx;
        tens_acc <= tens_nx;
        ones_acc <= ones_nx;
        step_q   <= step_q + 3'd1;
        if (last_step) begin
          tens_q    <= tens_nx;
          ones_q    <= ones_nx;
          last_conv <= conv_src;
          time_up_q <= (tens_nx == 4'd0) && (ones_nx == 4'd0);
        end
      end
    end
  end

  // Refresh divider: each digit stays lit for REFRESH_DIV cycles
  always_ff @(posedge clk_o) begin
    if (!rst) begin
      refresh_q <= '0;
      sel_q     <= 1'b0;
    end else if (refresh_q == REFRESH_LAST) begin
      refresh_q <= '0;
      sel_q     <= ~sel_q;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

`ifdef TIMER_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] blink_cnt_q;
  logic          blink_on_q;

  // Blink timer runs only while time is up; otherwise parked at count 0, phase on
  always_ff @(posedge clk_o) begin
    if (!rst || !time_up_q) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_on_q  <= ~blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blank = ~blink_on_q;
`else
  // Blink period has no effect when blinking is not built in
  localparam int unused_blink_div = BLINK_DIV;
  assign blank = 1'b0;
`endif

  // Anode select and active-low segment decode of the selected digit
  always_comb begin
    digit = sel_q ? tens_q : ones_q;
    an    = blank ? 4'b1111 : (sel_q ? 4'b1101 : 4'b1110);
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign dp      = 1'b1;
  assign time_up = time_up_q;

endmodule

// File: doc/timer_display.md
TIMER_DISPLAY -- requirements
Module: timer_display

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, sets the clk_o cycles each digit is lit (1 ms at 100 MHz).
REQ-002 Parameter BLINK_DIV, default 50000000, sets the clk_o cycles per blink half-period (0.5 s).
REQ-003 clk_o  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 count  in  6  remaining-seconds value from the countdown timer, unsigned 0..63.
REQ-006 an  out  4  7-segment anodes, active-low; an[0] = ones digit, an[1] = tens digit.
REQ-007 seg  out  7  segment cathodes, active-low, seg[0]=a ... seg[6]=g.
REQ-008 dp  out  1  decimal point, active-low; constant 1.
REQ-009 time_up  out  1  high while the converted value is 0.

Function
REQ-010 count shall be registered into cnt_q every cycle; all downstream logic uses only cnt_q.
REQ-011 Conversion FSM states: IDLE, SHIFT.
- IDLE -> SHIFT when cnt_q != last_conv; loads shift register with cnt_q and BCD accumulators with 0.
REQ-012 SHIFT shall run exactly 6 double-dabble steps, one per cycle; each step adds 3 to any BCD nibble >= 5, then shifts left one.
- After step 6: tens/ones and last_conv update together, and the FSM returns to IDLE.
REQ-013 Latency: tens/ones reflect a new count 8 cycles after it appears on count (1 sample, 1 load, 6 shifts).
- tens/ones hold their old values until then.
REQ-014 A count change during SHIFT shall not abort the conversion; the completed value is written, then IDLE restarts on the new mismatch.
REQ-015 Values 61..63 shall be displayed as-is; there is no saturation.
REQ-016 Refresh counter counts 0..REFRESH_DIV-1 and wraps; on wrap, digit select toggles.
- Select 0: an=4'b1110, ones shown.
- Select 1: an=4'b1101, tens shown.
- an[3:2] are always 1.
REQ-017 seg shall be the active-low decode of the selected BCD digit 0..9.
- 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001, 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000.
- Codes 10..15 give 7'b1111111.
REQ-018 The tens digit shall display 0 with no leading-zero blanking.
REQ-019 time_up = (tens==0 && ones==0); it is registered and changes on the same cycle tens/ones update.

Reset
REQ-020 While rst=0 at a clock edge:
- cnt_q=0, last_conv=0, tens=0, ones=0.
- FSM=IDLE, refresh counter=0, digit select=0.
- Blink counter=0, blink phase=on.
REQ-021 Outputs during and immediately after reset: an=4'b1110, seg=7'b1000000, dp=1, time_up=1.
REQ-022 Reset asserted mid-conversion shall discard the partial result.

Configuration
REQ-023 Macro TIMER_DISPLAY_BLINK_EN defined: while time_up=1, blink counter runs 0..BLINK_DIV-1 and toggles phase on wrap.
- Phase off forces an=4'b1111.
- When time_up falls, blink counter and phase return to 0/on on the next cycle.
REQ-024 Macro undefined: no blink logic; "00" is shown steadily while time_up=1.

Verification (REFRESH_DIV=4, BLINK_DIV=8)
REQ-025 Reset, then hold count=60 -> time_up falls 8 cycles after rst rises; tens=6 / ones=0 visible: an=1101 seg=0000010, an=1110 seg=1000000.
REQ-026 count steps 60->59 -> for 8 cycles the display still shows 60, then 59 (seg 0010010 / 0010000); an alternates every 4 cycles.
REQ-027 count 45->44 changed at conversion step 3 -> 45 is written first, then 44 appears 7 cycles later; no intermediate value is displayed.
REQ-028 count=0 with BLINK_EN -> time_up=1, an=1111 for 8 cycles, then 8 cycles of alternating 1110/1101 with seg=1000000; repeats. Without BLINK_EN -> no 1111 phase.
REQ-029 count=63 -> shows 63 (6: 0000010, 3: 0110000); rst=0 for 1 cycle mid-SHIFT -> outputs match REQ-021, and 63 reconverts afterward.
